// File: rtl/lsu_ctrl.sv
// Load/store sequencer: captures one EXU memory op, runs a req/gnt/rvalid bus transaction and
// returns the extended load result. Optional misalignment trap via `define LSU_MISALIGN_EXC_EN.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic        err_q, err_d;
  logic        misalign_q, misalign_d;
  logic        capture;
  logic        misaligned;
  logic        timeout_hit;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned = ((mem_size_i == 2'b01) && mem_addr_i[0]) ||
                      (mem_size_i[1] && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign timeout_hit = (cnt_q >= TO_LAST);
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign err_o       = err_q;

  // Next-state, watchdog and pipeline-facing outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    bus_req_d  = 1'b0;
    err_d      = 1'b0;
    misalign_d = 1'b0;
    capture    = 1'b0;
    stall_o    = 1'b0;
    rd_we_o    = 1'b0;
    rd_addr_o  = rd_addr_i;
    rd_data_o  = rd_data_i;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          stall_o = 1'b1;
          capture = 1'b1;
          if (misaligned) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            state_d   = REQ;
            cnt_d     = 8'd0;
            bus_req_d = 1'b1;
          end
        end else begin
          rd_we_o = rd_we_i;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // A grant in the timeout cycle still completes the access
        if (bus_gnt_i) begin
          state_d = we_q ? DONE : WAIT;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d   = IDLE;
        rd_we_o   = rd_we_q & ~we_q & ~err_q & ~misalign_q;
        rd_addr_o = rd_addr_q;
        rd_data_o = load_extract(rdata_q, addr_lo_q, size_q, uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, watchdog and registered bus/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      rdata_q    <= 32'd0;
      bus_req_q  <= 1'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_req_q  <= bus_req_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  // Instruction capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_lo_q   <= 2'd0;
      we_q        <= 1'b0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= 5'd0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
    end else if (capture) begin
      size_q      <= mem_size_i;
      uns_q       <= mem_unsigned_i;
      addr_lo_q   <= mem_addr_i[1:0];
      we_q        <= mem_we_i;
      rd_we_q     <= rd_we_i;
      rd_addr_q   <= rd_addr_i;
      bus_we_q    <= mem_we_i;
      bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
      bus_be_q    <= byte_en(mem_size_i, mem_addr_i[1:0]);
      bus_wdata_q <= store_data(mem_size_i, mem_wdata_i);
    end else begin
      size_q      <= size_q;
      bus_addr_q  <= bus_addr_q;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT_CYCLES=4) with a write-back scoreboard.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_i, mem_we_i, mem_unsigned_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic        rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o, rd_we_o, err_o, misalign_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;
  wb_t sb_q[$];

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .stall_o(stall_o),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .err_o(err_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, ".rd_we"}, 32'(rd_we_o), 32'(e.we));
      if (e.we) begin
        chk({tag, ".rd_addr"}, 32'(rd_addr_o), 32'(e.addr));
        chk({tag, ".rd_data"}, rd_data_o, e.data);
      end
    end
  endtask

  task automatic drive_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input logic [4:0] rda);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
    mem_addr_i = addr; mem_wdata_i = wdata;
    rd_we_i = ~we; rd_addr_i = rda; rd_data_i = 32'hFACE_0000;
  endtask

  task automatic release_op();
    mem_req_i = 1'b0; rd_we_i = 1'b0;
  endtask

  // Load with gnt at T1, rvalid at T2, write-back at T3
  task automatic load_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rdata, input logic [4:0] rda,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
    drive_op(1'b0, addr, size, uns, 32'h0, rda);
    sb_q.push_back('{1'b1, rda, exp_data});
    #1;
    chk({tag, ".t0_stall"}, 32'(stall_o), 32'd1);
    chk({tag, ".t0_rd_we"}, 32'(rd_we_o), 32'd0);
    tick();
    chk({tag, ".t1_req"}, 32'(bus_req_o), 32'd1);
    chk({tag, ".t1_addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
    chk({tag, ".t1_be"}, 32'(bus_be_o), 32'(exp_be));
    chk({tag, ".t1_we"}, 32'(bus_we_o), 32'd0);
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk({tag, ".t2_req"}, 32'(bus_req_o), 32'd0);
    chk({tag, ".t2_stall"}, 32'(stall_o), 32'd1);
    bus_rvalid_i = 1'b1; bus_rdata_i = rdata;
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk({tag, ".t3_stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".t3_err"}, 32'(err_o), 32'd0);
    check_wb(tag);
    tick();
    release_op();
    #1;
    chk({tag, ".t4_stall"}, 32'(stall_o), 32'd0);
  endtask

  // Store with the grant delayed by gnt_delay cycles after T1
  task automatic store_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input int gnt_delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    drive_op(1'b1, addr, size, 1'b0, wdata, 5'd0);
    sb_q.push_back('{1'b0, 5'd0, 32'h0});
    #1;
    chk({tag, ".t0_stall"}, 32'(stall_o), 32'd1);
    tick();
    chk({tag, ".req"}, 32'(bus_req_o), 32'd1);
    chk({tag, ".we"}, 32'(bus_we_o), 32'd1);
    chk({tag, ".addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
    chk({tag, ".be"}, 32'(bus_be_o), 32'(exp_be));
    chk({tag, ".wdata"}, bus_wdata_o, exp_wdata);
    repeat (gnt_delay) begin
      tick();
      chk({tag, ".req_hold"}, 32'(bus_req_o), 32'd1);
      chk({tag, ".stall_hold"}, 32'(stall_o), 32'd1);
    end
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk({tag, ".done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".done_req"}, 32'(bus_req_o), 32'd0);
    check_wb(tag);
    tick();
    release_op();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish before 200us");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_unsigned_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    rd_we_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'h0000_DEAD;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    #2;
    chk("rst.bus_req", 32'(bus_req_o), 32'd0);
    chk("rst.bus_we", 32'(bus_we_o), 32'd0);
    chk("rst.bus_addr", bus_addr_o, 32'd0);
    chk("rst.bus_be", 32'(bus_be_o), 32'd0);
    chk("rst.bus_wdata", bus_wdata_o, 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    chk("rst.misalign", 32'(misalign_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.rd_we", 32'(rd_we_o), 32'd1);
    chk("rst.rd_addr", 32'(rd_addr_o), 32'd3);
    chk("rst.rd_data", rd_data_o, 32'h0000_DEAD);
    mem_req_i = 1'b1;
    #1;
    chk("rst.stall_follow", 32'(stall_o), 32'd1);
    release_op();
    #1;
    rst_n = 1'b1;
    tick();

    // Passthrough
    rd_we_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'h0000_1234;
    #1;
    chk("pass.rd_we", 32'(rd_we_o), 32'd1);
    chk("pass.rd_addr", 32'(rd_addr_o), 32'd5);
    chk("pass.rd_data", rd_data_o, 32'h0000_1234);
    chk("pass.stall", 32'(stall_o), 32'd0);
    rd_we_i = 1'b0;
    tick();

    load_txn("lb",  32'h0000_0103, 2'b00, 1'b0, 32'h80FF_0000, 5'd7, 4'b1000, 32'hFFFF_FF80);
    load_txn("lbu", 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_0000, 5'd8, 4'b1000, 32'h0000_0080);
    load_txn("lh",  32'h0000_0002, 2'b01, 1'b0, 32'h8001_1234, 5'd12, 4'b1100, 32'hFFFF_8001);
    load_txn("lhu", 32'h0000_0000, 2'b01, 1'b1, 32'h8001_F234, 5'd13, 4'b0011, 32'h0000_F234);
    load_txn("lw",  32'h0000_0010, 2'b11, 1'b0, 32'h1357_9BDF, 5'd14, 4'b1111, 32'h1357_9BDF);

    store_txn("sh", 32'h0000_0202, 2'b01, 32'h0000_ABCD, 2, 4'b1100, 32'hABCD_ABCD);
    store_txn("sb", 32'h0000_0301, 2'b00, 32'h0000_005A, 0, 4'b0010, 32'h5A5A_5A5A);

    // Watchdog abort: no grant at all
    drive_op(1'b0, 32'h0000_0400, 2'b10, 1'b0, 32'h0, 5'd9);
    sb_q.push_back('{1'b0, 5'd9, 32'h0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to.req_high", 32'(bus_req_o), 32'd1);
      chk("to.err_low", 32'(err_o), 32'd0);
    end
    tick();
    chk("to.req_drop", 32'(bus_req_o), 32'd0);
    chk("to.err", 32'(err_o), 32'd1);
    chk("to.stall", 32'(stall_o), 32'd0);
    check_wb("to");
    tick();
    release_op();
    #1;
    chk("to.err_pulse", 32'(err_o), 32'd0);
    tick();

    // Grant in the timeout cycle wins
    drive_op(1'b0, 32'h0000_0404, 2'b10, 1'b0, 32'h0, 5'd10);
    sb_q.push_back('{1'b1, 5'd10, 32'h5555_AAAA});
    repeat (4) tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk("to_gnt.err", 32'(err_o), 32'd0);
    chk("to_gnt.stall", 32'(stall_o), 32'd1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("to_gnt.done_err", 32'(err_o), 32'd0);
    chk("to_gnt.done_stall", 32'(stall_o), 32'd0);
    check_wb("to_gnt");
    tick();
    release_op();
    tick();

`ifdef LSU_MISALIGN_EXC_EN
    drive_op(1'b0, 32'h0000_0001, 2'b10, 1'b0, 32'h0, 5'd11);
    sb_q.push_back('{1'b0, 5'd11, 32'h0});
    #1;
    chk("mis.t0_stall", 32'(stall_o), 32'd1);
    tick();
    chk("mis.req", 32'(bus_req_o), 32'd0);
    chk("mis.flag", 32'(misalign_o), 32'd1);
    chk("mis.stall", 32'(stall_o), 32'd0);
    check_wb("mis");
    tick();
    release_op();
    #1;
    chk("mis.pulse", 32'(misalign_o), 32'd0);
    tick();
`else
    load_txn("lw_unal", 32'h0000_0001, 2'b10, 1'b0, 32'hCAFE_BABE, 5'd11, 4'b1111, 32'hCAFE_BABE);
    load_txn("lh_unal", 32'h0000_0003, 2'b01, 1'b0, 32'h9ABC_0000, 5'd15, 4'b1100, 32'hFFFF_9ABC);
    chk("unal.misalign", 32'(misalign_o), 32'd0);
`endif

    // Asynchronous reset while requesting
    drive_op(1'b0, 32'h0000_0500, 2'b10, 1'b0, 32'h0, 5'd16);
    tick();
    chk("rst_req.before", 32'(bus_req_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_req.req", 32'(bus_req_o), 32'd0);
    chk("rst_req.be", 32'(bus_be_o), 32'd0);
    release_op();
    #1;
    rst_n = 1'b1;
    tick();

    // Asynchronous reset while waiting for read data
    drive_op(1'b0, 32'h0000_0600, 2'b10, 1'b0, 32'h0, 5'd17);
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk("rst_wait.stall_before", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    mem_req_i = 1'b0; rd_we_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h0000_0044;
    #1;
    chk("rst_wait.req", 32'(bus_req_o), 32'd0);
    chk("rst_wait.stall", 32'(stall_o), 32'd0);
    chk("rst_wait.rd_addr", 32'(rd_addr_o), 32'd4);
    rd_we_i = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("rst_wait.no_wb", 32'(rd_we_o), 32'd0);
    chk("rst_wait.idle", 32'(stall_o), 32'd0);
    store_txn("sw_after_rst", 32'h0000_0700, 2'b10, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344);

    chk("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
